// File: rtl/alu_sequencer.sv
// Issue/retire wrapper around a registered ALU: one operation in flight, {result, zero} returned downstream.
// Latency: res_valid 3 cycles after accept (2 with ALU_SEQ_LOCAL_ZERO_EN, flag computed locally from alu_out).
// Backpressure: cmd_ready only in IDLE; result held in DONE until res_ready, no new command accepted meanwhile.
module alu_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [1:0]   cmd_op,
    output logic [N-1:0] alu_in1,
    output logic [N-1:0] alu_in2,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_out,
    input  logic [N-1:0] alu_z,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_zero,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXEC   = 3'd1,
        WAIT_R = 3'd2,
        WAIT_Z = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = EXEC;
            EXEC:    state_nxt = WAIT_R;
`ifdef ALU_SEQ_LOCAL_ZERO_EN
            WAIT_R:  state_nxt = DONE;
`else
            WAIT_R:  state_nxt = WAIT_Z;
            WAIT_Z:  state_nxt = DONE;
`endif
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        busy      = (state != IDLE);
    end

    // Operand registers only move on an accept; results only on their capture edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_in1 <= cmd_a;
                        alu_in2 <= cmd_b;
                        alu_op  <= cmd_op;
                    end
                end
                WAIT_R: begin
                    res_data <= alu_out;
`ifdef ALU_SEQ_LOCAL_ZERO_EN
                    res_zero  <= (alu_out == '0);
                    res_valid <= 1'b1;
`endif
                end
`ifndef ALU_SEQ_LOCAL_ZERO_EN
                // The ALU's z lags its result by one cycle, so the flag is taken here, not in WAIT_R.
                WAIT_Z: begin
                    res_zero  <= alu_z[0];
                    res_valid <= 1'b1;
                end
`endif
                DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic unused_z;
`ifdef ALU_SEQ_LOCAL_ZERO_EN
    assign unused_z = ^alu_z;
`else
    assign unused_z = ^alu_z[N-1:1];
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural registered ALU; scoreboard queue checked by a negedge monitor.
module tb_alu_sequencer;

`ifdef ALU_SEQ_LOCAL_ZERO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic [1:0] cmd_op = '0;
    logic [7:0] alu_in1, alu_in2;
    logic [1:0] alu_op;
    logic [7:0] alu_out = '0;
    logic [7:0] alu_z = '0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       res_zero;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int retires = 0;
    logic [8:0] exp_q[$];
    int         acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .busy(busy)
    );

    // Registered ALU: result one cycle after operands, zero flag one cycle after the result.
    always @(posedge clk) begin
        case (alu_op)
            2'd0: alu_out <= alu_in1 + alu_in2;
            2'd1: alu_out <= alu_in1 - alu_in2;
            2'd2: alu_out <= alu_in1 * alu_in2;
            default: alu_out <= (alu_in2 >= 8'd8) ? 8'd0 : (alu_in1 << alu_in2);
        endcase
        alu_z <= {7'd0, (alu_out == 8'd0)};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout (cycle %0d)", name, cyc);
    endtask

    // Called in the posedge+1 phase; returns in the same phase just after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic [7:0] ed, input logic ez, input bit push);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            timeout("issue_wait");
            return;
        end
        if (push) exp_q.push_back({ed, ez});
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        cmd_op = 2'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || res_valid || busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || res_valid || busy) timeout("wait_idle");
    endtask

    initial begin : monitor
        bit         prev_vld = 0;
        bit         retire_prev = 0;
        logic [8:0] hold = '0;
        logic [8:0] e;
        int         acc;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_q.delete();
                prev_vld = 0;
                retire_prev = 0;
            end else begin
                if (retire_prev) begin
                    chk("vld_drop_after_retire", res_valid, 0);
                    chk("rdy_after_retire", cmd_ready, 1);
                end
                retire_prev = 0;
                if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
                if (res_valid) begin
                    chk("cmd_rdy_while_valid", cmd_ready, 0);
                    if (!prev_vld) begin
                        if (acc_q.size() == 0) begin
                            timeout("latency_no_accept");
                        end else begin
                            acc = acc_q.pop_front();
                            chk("latency", cyc - acc, LAT);
                        end
                        hold = {res_data, res_zero};
                    end else begin
                        chk("res_stable", {res_data, res_zero}, hold);
                    end
                    if (res_ready) begin
                        retires++;
                        retire_prev = 1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result data=%0d zero=%0d", res_data, res_zero);
                        end else begin
                            e = exp_q.pop_front();
                            chk("res_data", res_data, e[8:1]);
                            chk("res_zero", res_zero, e[0]);
                        end
                    end
                end
                prev_vld = res_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int r0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_zero", res_zero, 0);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", cmd_ready, 1);

        issue(8'd5, 8'd3, 2'd0, 8'd8, 1'b0, 1);
        chk("alu_in1_loaded", alu_in1, 5);
        chk("alu_in2_loaded", alu_in2, 3);
        chk("busy_exec", busy, 1);
        issue(8'd7, 8'd7, 2'd1, 8'd0, 1'b1, 1);
        issue(8'd20, 8'd13, 2'd2, 8'd4, 1'b0, 1);
        issue(8'd1, 8'd8, 2'd3, 8'd0, 1'b1, 1);
        issue(8'd3, 8'd2, 2'd3, 8'd12, 1'b0, 1);
        issue(8'd9, 8'd9, 2'd1, 8'd0, 1'b1, 1);
        issue(8'd1, 8'd1, 2'd0, 8'd2, 1'b0, 1);
        wait_idle();
        chk("operands_held", {alu_in1, alu_in2, alu_op}, {8'd1, 8'd1, 2'd0});

        // Backpressure: result held for 4 cycles while spurious commands are offered.
        res_ready = 1'b0;
        r0 = retires;
        issue(8'd200, 8'd100, 2'd0, 8'd44, 1'b0, 1);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!res_valid) timeout("bp_valid");
        for (int i = 0; i < 4; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_a = 8'd9;
            cmd_b = 8'd1;
            cmd_op = 2'd2;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        chk("bp_single_retire", retires - r0, 1);
        chk("bp_operands_unchanged", alu_in1, 200);

        // Reset while the add is in WAIT_R: the in-flight result must never appear.
        issue(8'd1, 8'd1, 2'd0, 8'd2, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_data", res_data, 0);
        chk("midrst_res_zero", res_zero, 0);
        chk("midrst_alu_in", {alu_in1, alu_in2, alu_op}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("midrst_rdy_release", cmd_ready, 1);
        issue(8'd2, 8'd2, 2'd0, 8'd4, 1'b0, 1);
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_retires", retires, 9);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue/retire stage wrapped around the registered ALU (N-bit add/sub/mul/shift, one-cycle result register, zero flag one cycle after the result).
- Accepts one operation at a time from the upstream decode/control logic over a valid/ready handshake.
- Drives the ALU operand and opcode ports from registers.
- Waits out the ALU's result and zero-flag latencies, then presents {result, zero} downstream over a second valid/ready handshake.
- Single outstanding operation; no pipelining across commands.

Parameters:
N, 8, datapath width; must match the ALU's N.

Ports:
clk        input   1    system clock, all logic on rising edge
rst        input   1    synchronous, active-high reset
cmd_valid  input   1    upstream offers an operation
cmd_ready  output  1    block can accept an operation
cmd_a      input   N    operand 1
cmd_b      input   N    operand 2
cmd_op     input   2    0 add, 1 sub (a-b), 2 mul, 3 shift left (a<<b)
alu_in1    output  N    to ALU in1
alu_in2    output  N    to ALU in2
alu_op     output  2    to ALU alu_op
alu_out    input   N    from ALU alu_out (registered, 1-cycle latency)
alu_z      input   N    from ALU z; only bit 0 used
res_valid  output  1    result available
res_ready  input   1    downstream accepts result
res_data   output  N    captured ALU result
res_zero   output  1    captured zero flag
busy       output  1    high whenever state != IDLE

Behaviour:
- One clock (clk); synchronous active-high reset (rst).
- Reset values: alu_in1=0, alu_in2=0, alu_op=0, res_valid=0, res_data=0, res_zero=0, state=IDLE.
- cmd_ready = (state==IDLE) && !rst. Combinational from state; never depends on cmd_valid.
- States: IDLE -> EXEC -> WAIT_R -> WAIT_Z -> DONE -> IDLE.
- IDLE: on cmd_valid && cmd_ready at edge k, load alu_in1/alu_in2/alu_op from cmd_a/cmd_b/cmd_op; go to EXEC.
- EXEC (cycle after k): operands stable on ALU ports. At edge k+1 the ALU registers the result; go to WAIT_R.
- WAIT_R: at edge k+2 capture res_data <= alu_out; go to WAIT_Z. The ALU's z updates on this same edge.
- WAIT_Z: at edge k+3 capture res_zero <= alu_z[0], set res_valid <= 1; go to DONE.
- Latency: res_valid rises 3 cycles after the accept edge. Throughput: one operation per 5 cycles when res_ready is held high.
- DONE:
  - res_valid held high; res_data/res_zero held stable until res_valid && res_ready.
  - On that edge: res_valid <= 0, go to IDLE.
  - cmd_ready stays low throughout DONE, so a new command is never accepted on the same edge a result retires.
- alu_in1/alu_in2/alu_op hold their last values between operations; they change only on an accept edge.
- cmd_a/cmd_b/cmd_op are don't-care outside the accept edge.
- Arithmetic is entirely the ALU's:
  - add/sub wrap mod 2^N.
  - mul truncated to the low N bits.
  - shift amount is the full alu_in2 value; shift by >= N yields 0.
  - This block never modifies operands or results.
- Reset mid-operation (any state): next cycle state=IDLE, res_valid=0, all captured data cleared. An in-flight ALU result is discarded, never presented.
- res_ready high while not in DONE: ignored.
- cmd_valid high while busy: ignored, not queued.

Optional Feature:
ALU_SEQ_LOCAL_ZERO_EN
- Defined:
  - WAIT_Z is removed.
  - At edge k+2, capture res_data <= alu_out and res_zero <= (alu_out == 0), and set res_valid <= 1.
  - Latency becomes 2 cycles; throughput becomes 1 operation per 4 cycles.
  - alu_z is unused.
- Undefined: behaviour exactly as above, with the flag taken from alu_z[0].

Test Plan (N=8, bench instantiates the ALU and this block together):
- add a=5 b=3, res_ready=1 -> res_valid exactly 3 cycles after accept, res_data=8, res_zero=0, res_valid drops the next cycle, cmd_ready=1 the cycle after.
- sub a=7 b=7 immediately after a nonzero result -> res_data=0, res_zero=1. Checks that the flag comes from the new result, not the stale one.
- mul a=20 b=13 -> res_data=4 (260 mod 256), res_zero=0; shift a=1 b=8 -> res_data=0, res_zero=1.
- Backpressure: add a=200 b=100, res_ready=0 for 4 cycles after res_valid, then 1 -> res_data=44 stable throughout, cmd_ready=0 throughout, cmd_valid pulses during the wait are ignored, retire exactly once.
- Reset in WAIT_R during add a=1 b=1 -> res_valid never asserts, all outputs 0 the cycle after rst, cmd_ready=1 once rst deasserts, next op (add 2+2) returns 4.
- ALU_SEQ_LOCAL_ZERO_EN defined: sub 9-9 -> res_valid 2 cycles after accept, res_data=0, res_zero=1; add 1+1 -> res_zero=0.
